// File: rtl/bomberman_map_pkg.sv
// ---------------------------------------------------------------------------
// bomberman_map_pkg
//
// Shared map geometry, tile encoding and arbitration constants. The map
// memory, the write arbiter and the multi-read controller all use it.
//
// Contents:
//   MAP_NUM_ROW / MAP_NUM_COL  playfield size in tiles (11 x 19)
//   MAP_DEPTH                  number of tiles
//   MAP_ADDR_WIDTH             map memory address width
//   MAP_MEM_WIDTH              tile code width
//   tile_t                     2-bit tile codes
//   ARB_RR / ARB_FIXED         arbitration mode selectors
//   idx_width()                index width for an N-entry vector (minimum 1)
// ---------------------------------------------------------------------------
package bomberman_map_pkg;

    localparam int MAP_NUM_ROW    = 11;
    localparam int MAP_NUM_COL    = 19;
    localparam int MAP_DEPTH      = MAP_NUM_ROW * MAP_NUM_COL;
    localparam int MAP_ADDR_WIDTH = $clog2(MAP_DEPTH);
    localparam int MAP_MEM_WIDTH  = 2;

    typedef enum logic [1:0] {
        TILE_FREE    = 2'd0,
        TILE_BLOCK   = 2'd1,
        TILE_BOMB    = 2'd2,
        TILE_POWERUP = 2'd3
    } tile_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // A 1-entry vector still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/map_rr_pick.sv
// ---------------------------------------------------------------------------
// map_rr_pick
//
// Combinational single-winner picker over a request vector.
//   mode = 0 : round-robin; search starts at ptr and wraps to index 0.
//   mode = 1 : fixed priority; the lowest set index wins and ptr is ignored.
//
// Ports:
//   valid  in   NUM    request vector
//   ptr    in   IDX_W  round-robin start index (must be < NUM)
//   mode   in   1      0 = round-robin, 1 = fixed priority
//   grant  out  NUM    one-hot winner, all zero when nothing is valid
//   idx    out  IDX_W  binary index of the winner (0 when nothing is valid)
//   found  out  1      a winner exists
// ---------------------------------------------------------------------------
module map_rr_pick
    import bomberman_map_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int IDX_W = idx_width(NUM)
) (
    input  logic [NUM-1:0]   valid,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [NUM-1:0]   grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Two ordered passes implement the wrap without a rotator: the first pass
    // covers [ptr, NUM-1] (or everything in fixed mode), and the second pass
    // covers the wrapped part [0, ptr-1].
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < NUM; j++) begin
            if (!found && valid[j] && (mode || (j >= int'(ptr)))) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM; j++) begin
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/map_write_arbiter.sv
// ---------------------------------------------------------------------------
// map_write_arbiter
//
// N-channel write arbiter in front of the map memory write port. Each channel
// owns a one-entry pending buffer, so a single-cycle write pulse that collides
// with other channels is held until it is granted instead of being lost. At
// most one registered map write is issued per cycle. An uncontended write
// reaches mem_we exactly two cycles after its request pulse.
//
// Parameters:
//   NUM_WR    number of write channels (1..16)
//   ADDR_W    map address width
//   DATA_W    tile data width
//   ARB_MODE  ARB_RR (0) = round-robin, ARB_FIXED (1) = lowest index wins
//
// Build option:
//   MAP_WR_COALESCE_EN  when defined, a blocked request to the same address
//                       as its channel's pending entry replaces that entry's
//                       data (the last write wins) instead of overflowing.
//
// Ports:
//   clk         in   1              pixel clock
//   rst         in   1              synchronous active-high reset
//   wr_req      in   NUM_WR         per-channel write pulse
//   wr_addr_in  in   NUM_WR*ADDR_W  per-channel tile address
//   wr_data_in  in   NUM_WR*DATA_W  per-channel tile data
//   wr_busy     out  NUM_WR         pending entry valid
//   wr_done     out  NUM_WR         pulse in the cycle the channel's write is on mem_we
//   ovf         out  NUM_WR         sticky: a request was dropped
//   ovf_clr     in   1              clears all ovf bits (a same-cycle set wins)
//   mem_we      out  1              map memory write enable
//   mem_addr    out  ADDR_W         map memory write address (holds when idle)
//   mem_data    out  DATA_W         map memory write data (holds when idle)
// ---------------------------------------------------------------------------
module map_write_arbiter
    import bomberman_map_pkg::*;
#(
    parameter int NUM_WR   = 4,
    parameter int ADDR_W   = MAP_ADDR_WIDTH,
    parameter int DATA_W   = MAP_MEM_WIDTH,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              wr_req,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_in,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_in,
    output logic [NUM_WR-1:0]              wr_busy,
    output logic [NUM_WR-1:0]              wr_done,
    output logic [NUM_WR-1:0]              ovf,
    input  logic                           ovf_clr,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_data
);

    localparam int   IDX_W = idx_width(NUM_WR);
    localparam logic FIXED = 1'(ARB_MODE == ARB_FIXED);

`ifdef MAP_WR_COALESCE_EN
    localparam logic COALESCE = 1'b1;
`else
    localparam logic COALESCE = 1'b0;
`endif

    // Pending buffers
    logic [NUM_WR-1:0]             pend_valid_q, pend_valid_d;
    logic [NUM_WR-1:0][ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic [NUM_WR-1:0][DATA_W-1:0] pend_data_q,  pend_data_d;

    // Arbitration and issue state
    logic [IDX_W-1:0]  ptr_q,  ptr_d;
    logic [NUM_WR-1:0] ovf_q,  ovf_d;
    logic [NUM_WR-1:0] done_q, done_d;
    logic              we_q,   we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Picker results
    logic [NUM_WR-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;

    // A channel can accept a new request when it is empty or when its
    // current entry leaves on this edge.
    logic [NUM_WR-1:0] slot_free;

    map_rr_pick #(
        .NUM   (NUM_WR),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (pend_valid_q),
        .ptr   (ptr_q),
        .mode  (FIXED),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_any)
    );

    assign slot_free = ~pend_valid_q | grant;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        ptr_d        = ptr_q;
        ovf_d        = ovf_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = grant_any;
        done_d       = grant;

        // Issue: the winner moves into the output registers.
        if (grant_any) begin
            addr_d = pend_addr_q[grant_idx];
            data_d = pend_data_q[grant_idx];
            if (!FIXED) begin
                ptr_d = (grant_idx == IDX_W'(NUM_WR - 1)) ? '0 : grant_idx + 1'b1;
            end
        end

        // Clear first so that an overflow on the same edge still sets its bit.
        if (ovf_clr) begin
            ovf_d = '0;
        end

        for (int k = 0; k < NUM_WR; k++) begin
            if (grant[k]) begin
                pend_valid_d[k] = 1'b0;
            end
            if (wr_req[k]) begin
                if (slot_free[k]) begin
                    pend_valid_d[k] = 1'b1;
                    pend_addr_d[k]  = wr_addr_in[k];
                    pend_data_d[k]  = wr_data_in[k];
                end else if (COALESCE && (wr_addr_in[k] == pend_addr_q[k])) begin
                    pend_data_d[k] = wr_data_in[k];
                end else begin
                    ovf_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= '0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            ptr_q        <= '0;
            ovf_q        <= '0;
            done_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            ptr_q        <= ptr_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign wr_busy  = pend_valid_q;
    assign wr_done  = done_q;
    assign ovf      = ovf_q;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;

endmodule
